// File: rtl/mmu_iplru32.sv
`default_nettype none
// ============================================================================
// Module      : mmu_iplru32
// Description : 32-entry tree pseudo-LRU victim selector for the instruction
//               micro-TLB. A 31-node binary tree (heap order, node 1 = root,
//               node k has children 2k/2k+1, nodes 16..31 pick between entry
//               pairs) records recency from read hits and refills. The
//               one-hot victim plru_iutlb_ref_num prefers the lowest-index
//               invalid entry, otherwise the entry reached by walking the
//               tree (bit 0 = go left, bit 1 = go right).
// Options     : MMU_IPLRU_ICG_EN - when defined, the tree register is clocked
//               through gated_clk_cell; otherwise it runs on forever_cpuclk
//               with a synchronous load enable. Cycle behaviour is identical.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_iplru32 (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        cp0_mmu_icg_en,
    input  logic        pad_yy_icg_scan_en,
    input  logic        entry0_vld,
    input  logic        entry1_vld,
    input  logic        entry2_vld,
    input  logic        entry3_vld,
    input  logic        entry4_vld,
    input  logic        entry5_vld,
    input  logic        entry6_vld,
    input  logic        entry7_vld,
    input  logic        entry8_vld,
    input  logic        entry9_vld,
    input  logic        entry10_vld,
    input  logic        entry11_vld,
    input  logic        entry12_vld,
    input  logic        entry13_vld,
    input  logic        entry14_vld,
    input  logic        entry15_vld,
    input  logic        entry16_vld,
    input  logic        entry17_vld,
    input  logic        entry18_vld,
    input  logic        entry19_vld,
    input  logic        entry20_vld,
    input  logic        entry21_vld,
    input  logic        entry22_vld,
    input  logic        entry23_vld,
    input  logic        entry24_vld,
    input  logic        entry25_vld,
    input  logic        entry26_vld,
    input  logic        entry27_vld,
    input  logic        entry28_vld,
    input  logic        entry29_vld,
    input  logic        entry30_vld,
    input  logic        entry31_vld,
    input  logic        utlb_plru_read_hit_vld,
    input  logic [31:0] utlb_plru_read_hit,
    input  logic        utlb_plru_refill_on,
    input  logic        utlb_plru_refill_vld,
    output logic [31:0] plru_iutlb_ref_num
);

    localparam int C_ENTRIES = 32;
    localparam int C_LEVELS  = 5;

    // Tree state: bit k holds node k (k = 1..31).
    logic [31:1] tree_q;
    logic [31:1] tree_d;

    logic [31:0] w_entry_vld;
    logic        w_any_invalid;
    logic [4:0]  w_inv_idx;
    logic [4:0]  w_walk_idx;
    logic [5:0]  w_walk_node;
    logic [4:0]  w_victim_idx;
    logic [4:0]  w_hit_idx;
    logic        w_hit_any;
    logic        w_touch_en;
    logic [4:0]  w_touch_idx;
    logic [4:0]  w_upd_node;
    logic [31:1] w_tree_upd;
    logic        w_tree_clk;

    assign w_entry_vld = {entry31_vld, entry30_vld, entry29_vld, entry28_vld,
                          entry27_vld, entry26_vld, entry25_vld, entry24_vld,
                          entry23_vld, entry22_vld, entry21_vld, entry20_vld,
                          entry19_vld, entry18_vld, entry17_vld, entry16_vld,
                          entry15_vld, entry14_vld, entry13_vld, entry12_vld,
                          entry11_vld, entry10_vld, entry9_vld,  entry8_vld,
                          entry7_vld,  entry6_vld,  entry5_vld,  entry4_vld,
                          entry3_vld,  entry2_vld,  entry1_vld,  entry0_vld};

    // Lowest-index invalid entry; scanning downward leaves the lowest match.
    always_comb begin
        w_any_invalid = 1'b0;
        w_inv_idx     = 5'd0;
        for (int i = C_ENTRIES - 1; i >= 0; i--) begin
            if (!w_entry_vld[i]) begin
                w_any_invalid = 1'b1;
                w_inv_idx     = 5'(i);
            end
        end
    end

    // Walk the tree from the root; after five steps the node number minus 32
    // is the leaf entry index.
    always_comb begin
        w_walk_node = 6'd1;
        for (int l = 0; l < C_LEVELS; l++) begin
            w_walk_node = {w_walk_node[4:0], tree_q[w_walk_node[4:0]]};
        end
        w_walk_idx = w_walk_node[4:0];
    end

    // Final victim: invalid entries always win over the tree choice.
    always_comb begin
        w_victim_idx       = w_any_invalid ? w_inv_idx : w_walk_idx;
        plru_iutlb_ref_num = 32'd1 << w_victim_idx;
    end

    // Lowest-index set bit of the hit vector; multi-hot resolves low.
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_idx = 5'd0;
        for (int i = C_ENTRIES - 1; i >= 0; i--) begin
            if (utlb_plru_read_hit[i]) begin
                w_hit_any = 1'b1;
                w_hit_idx = 5'(i);
            end
        end
    end

    // Refill outranks a same-cycle hit, and the refilled entry is the
    // current victim; a qualified but empty hit vector touches nothing.
    always_comb begin
        w_touch_en  = utlb_plru_refill_vld | (utlb_plru_read_hit_vld & w_hit_any);
        w_touch_idx = utlb_plru_refill_vld ? w_victim_idx : w_hit_idx;
    end

    // Point every node on the root-to-entry path away from the touched entry.
    // The node at depth d is (1 << d) + (idx >> (5 - d)); the entry lies in
    // that node's left half when idx bit (4 - d) is 0, so the node gets 1.
    always_comb begin
        w_tree_upd = tree_q;
        w_upd_node = 5'd1;
        for (int d = 0; d < C_LEVELS; d++) begin
            w_upd_node             = 5'((1 << d) | (32'(w_touch_idx) >> (C_LEVELS - d)));
            w_tree_upd[w_upd_node] = ~w_touch_idx[3'(C_LEVELS - 1 - d)];
        end
        tree_d = w_touch_en ? w_tree_upd : tree_q;
    end

`ifdef MMU_IPLRU_ICG_EN
    logic w_icg_local_en;

    assign w_icg_local_en = utlb_plru_read_hit_vld | utlb_plru_refill_vld
                          | utlb_plru_refill_on;

    // Clock runs when any request is pending, when gating is disabled by
    // cp0_mmu_icg_en (module enable) or when scan forces it on.
    gated_clk_cell x_mmu_iplru_gated_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (cp0_mmu_icg_en),
        .local_en           (w_icg_local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (w_tree_clk)
    );
`else
    logic w_unused_icg;

    assign w_tree_clk   = forever_cpuclk;
    // Gating controls only matter in the gated-clock build.
    assign w_unused_icg = &{1'b0, cp0_mmu_icg_en, pad_yy_icg_scan_en,
                            utlb_plru_refill_on};
`endif

    // Tree state register; reset points every node left, selecting entry 0.
    always_ff @(posedge w_tree_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmu_iplru32.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_iplru32
// Description : Self-checking bench for mmu_iplru32. Table of one-cycle
//               vectors with hand-derived victims fed through an expected-
//               value queue, plus short sequences for async reset and
//               combinational valid changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_iplru32;

    localparam logic [31:0] C_ALL  = 32'hFFFF_FFFF;
    localparam logic [31:0] C_NO5  = 32'hFFFF_FFDF;
    localparam logic [31:0] C_NO37 = 32'hFFFF_FF77;
    localparam int          C_NVEC = 19;

    typedef struct {
        logic        rst;
        logic [31:0] vld;
        logic        hit_vld;
        logic [31:0] hit;
        logic        refill_on;
        logic        refill_vld;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        icg_en;
    logic        scan_en;
    logic [31:0] vld;
    logic        hit_vld;
    logic [31:0] hit;
    logic        refill_on;
    logic        refill_vld;
    logic [31:0] ref_num;

    int          n_checks;
    int          n_fails;
    logic [31:0] sb_q[$];
    vec_t        vecs[C_NVEC];
    logic [31:0] exp_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mmu_iplru32 dut (
        .forever_cpuclk         (clk),
        .cpurst_b               (rst_n),
        .cp0_mmu_icg_en         (icg_en),
        .pad_yy_icg_scan_en     (scan_en),
        .entry0_vld             (vld[0]),
        .entry1_vld             (vld[1]),
        .entry2_vld             (vld[2]),
        .entry3_vld             (vld[3]),
        .entry4_vld             (vld[4]),
        .entry5_vld             (vld[5]),
        .entry6_vld             (vld[6]),
        .entry7_vld             (vld[7]),
        .entry8_vld             (vld[8]),
        .entry9_vld             (vld[9]),
        .entry10_vld            (vld[10]),
        .entry11_vld            (vld[11]),
        .entry12_vld            (vld[12]),
        .entry13_vld            (vld[13]),
        .entry14_vld            (vld[14]),
        .entry15_vld            (vld[15]),
        .entry16_vld            (vld[16]),
        .entry17_vld            (vld[17]),
        .entry18_vld            (vld[18]),
        .entry19_vld            (vld[19]),
        .entry20_vld            (vld[20]),
        .entry21_vld            (vld[21]),
        .entry22_vld            (vld[22]),
        .entry23_vld            (vld[23]),
        .entry24_vld            (vld[24]),
        .entry25_vld            (vld[25]),
        .entry26_vld            (vld[26]),
        .entry27_vld            (vld[27]),
        .entry28_vld            (vld[28]),
        .entry29_vld            (vld[29]),
        .entry30_vld            (vld[30]),
        .entry31_vld            (vld[31]),
        .utlb_plru_read_hit_vld (hit_vld),
        .utlb_plru_read_hit     (hit),
        .utlb_plru_refill_on    (refill_on),
        .utlb_plru_refill_vld   (refill_vld),
        .plru_iutlb_ref_num     (ref_num)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: ref_num got %h, expected %h", name, act, exp);
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #100000;
        n_fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;

        //            rst   vld     hvld  hit            ron   rvld  expected victim
        vecs[0]  = '{1'b0, C_ALL,  1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000};
        vecs[1]  = '{1'b1, C_ALL,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001};
        vecs[2]  = '{1'b0, C_ALL,  1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0001};
        vecs[3]  = '{1'b0, C_ALL,  1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001};
        vecs[4]  = '{1'b0, C_ALL,  1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0001_0000};
        vecs[5]  = '{1'b0, C_ALL,  1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0100};
        vecs[6]  = '{1'b0, C_ALL,  1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100};
        vecs[7]  = '{1'b0, C_ALL,  1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0100_0000};
        vecs[8]  = '{1'b0, C_ALL,  1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 32'h0100_0000};
        vecs[9]  = '{1'b0, C_ALL,  1'b1, 32'h4000_0000, 1'b0, 1'b0, 32'h0000_0010};
        vecs[10] = '{1'b0, C_NO5,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0020};
        vecs[11] = '{1'b0, C_NO5,  1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0020};
        vecs[12] = '{1'b0, C_ALL,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0010_0000};
        vecs[13] = '{1'b1, C_ALL,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001};
        vecs[14] = '{1'b0, C_ALL,  1'b1, 32'h0000_0002, 1'b1, 1'b1, 32'h0001_0000};
        vecs[15] = '{1'b1, C_ALL,  1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001};
        vecs[16] = '{1'b0, C_ALL,  1'b1, 32'h0001_0000, 1'b1, 1'b1, 32'h0001_0000};
        vecs[17] = '{1'b0, C_ALL,  1'b1, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0100};
        vecs[18] = '{1'b0, C_NO37, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0008};

        rst_n      = 1'b0;
        icg_en     = 1'b0;
        scan_en    = 1'b0;
        vld        = C_ALL;
        hit_vld    = 1'b0;
        hit        = 32'h0;
        refill_on  = 1'b0;
        refill_vld = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", ref_num, 32'h0000_0001);
        @(negedge clk);
        rst_n = 1'b1;

        // One vector per cycle: drive at the falling edge, sample after the rising edge.
        for (int i = 0; i < C_NVEC; i++) begin
            @(negedge clk);
            rst_n      = ~vecs[i].rst;
            vld        = vecs[i].vld;
            hit_vld    = vecs[i].hit_vld;
            hit        = vecs[i].hit;
            refill_on  = vecs[i].refill_on;
            refill_vld = vecs[i].refill_vld;
            sb_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL vec%0d: scoreboard empty, got %h", i, ref_num);
            end else begin
                exp_v = sb_q.pop_front();
                check($sformatf("vec%0d", i), ref_num, exp_v);
            end
            rst_n = 1'b1;
        end

        // Asynchronous reset mid-cycle clears the tree without a clock edge.
        @(negedge clk);
        vld        = C_ALL;
        hit_vld    = 1'b0;
        hit        = 32'h0;
        refill_on  = 1'b0;
        refill_vld = 1'b0;
        @(posedge clk);
        #1;
        check("pre_async_rst", ref_num, 32'h0000_0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", ref_num, 32'h0000_0001);
        @(negedge clk);
        rst_n = 1'b1;

        // Valid changes steer the output combinationally and leave the tree alone.
        @(negedge clk);
        hit_vld = 1'b1;
        hit     = 32'h0000_0001;
        @(posedge clk);
        #1;
        hit_vld = 1'b0;
        hit     = 32'h0;
        check("hit0_after_rst", ref_num, 32'h0001_0000);
        vld[5] = 1'b0;
        #1;
        check("entry5_invalid", ref_num, 32'h0000_0020);
        vld[5] = 1'b1;
        #1;
        check("entry5_restored", ref_num, 32'h0001_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
